// File: rtl/dist_pipe_pkg.sv
// Shared types for the distribution-datapath pipeline controller.
// State encoding, register-index width and the control output bundle.
package dist_pipe_pkg;

  localparam int DALU_LAT_DEF = 4;
  localparam int CNT_W_DEF    = 4;
  localparam int REG_W        = 5;

  typedef enum logic {
    RUN  = 1'b0,
    BUSY = 1'b1
  } state_e;

  typedef struct packed {
    logic id_ex_we;
    logic id_ex_clr;
    logic ex_mem_we;
    logic ex_mem_clr;
    logic front_stall;
    logic dalu_start;
    logic busy;
  } ctrl_out_t;

  // Both registers advance, nothing squashed.
  localparam ctrl_out_t CTRL_IDLE = '{
    id_ex_we:    1'b1,
    id_ex_clr:   1'b0,
    ex_mem_we:   1'b1,
    ex_mem_clr:  1'b0,
    front_stall: 1'b0,
    dalu_start:  1'b0,
    busy:        1'b0
  };

  // Both registers load bubbles while reset is held.
  localparam ctrl_out_t CTRL_RST = '{
    id_ex_we:    1'b1,
    id_ex_clr:   1'b1,
    ex_mem_we:   1'b1,
    ex_mem_clr:  1'b1,
    front_stall: 1'b1,
    dalu_start:  1'b0,
    busy:        1'b0
  };

endpackage

// File: rtl/dist_pipe_ctrl_if.sv
// Pipeline-side hazard inputs and register control outputs.
// master = pipeline datapath, slave = controller.
interface dist_pipe_ctrl_if;
  import dist_pipe_pkg::*;

  logic             id_valid;
  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             ex_dist_op;
  logic             ex_dist_load;
  logic [REG_W-1:0] ex_rd;
  logic             flush_req;
  logic             stall_ext;

  logic id_ex_we;
  logic id_ex_clr;
  logic ex_mem_we;
  logic ex_mem_clr;
  logic front_stall;
  logic dalu_start;
  logic busy;

  modport master (
    output id_valid, id_rs1, id_rs2,
    output ex_dist_op, ex_dist_load, ex_rd,
    output flush_req, stall_ext,
    input  id_ex_we, id_ex_clr,
    input  ex_mem_we, ex_mem_clr,
    input  front_stall, dalu_start, busy
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2,
    input  ex_dist_op, ex_dist_load, ex_rd,
    input  flush_req, stall_ext,
    output id_ex_we, id_ex_clr,
    output ex_mem_we, ex_mem_clr,
    output front_stall, dalu_start, busy
  );

endinterface

// File: rtl/dist_hazard_detect.sv
// Load-use comparator between the EX distribution load and ID sources.
// Register 0 never creates a dependency.
module dist_hazard_detect
  import dist_pipe_pkg::*;
(
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             ex_dist_load,
  input  logic             id_valid,
  output logic             hazard
);

  logic rd_nz;
  logic src_hit;

  // Match the load destination against either ID source.
  always_comb begin
    rd_nz   = |ex_rd;
    src_hit = (ex_rd == id_rs1) | (ex_rd == id_rs2);
    hazard  = ex_dist_load & id_valid & rd_nz & src_hit;
  end

endmodule

// File: rtl/dist_pipe_ctrl.sv
// Stall/flush controller for the ID/EX and EX/MEM distribution registers.
// Sequences multi-cycle DALU ops and resolves load-use, stall and flush.
module dist_pipe_ctrl
  import dist_pipe_pkg::*;
#(
  parameter int DALU_LAT = DALU_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  dist_pipe_ctrl_if.slave    bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DALU_LAT - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hazard;
  ctrl_out_t        ctrl;

  dist_hazard_detect u_hazard (
    .ex_rd        (bus.ex_rd),
    .id_rs1       (bus.id_rs1),
    .id_rs2       (bus.id_rs2),
    .ex_dist_load (bus.ex_dist_load),
    .id_valid     (bus.id_valid),
    .hazard       (hazard)
  );

  // Next-state, counter and output mux; RUN cases in priority order.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ctrl    = CTRL_IDLE;
    if (!rst_n) begin
      ctrl    = CTRL_RST;
      state_d = RUN;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        RUN: begin
          if (bus.stall_ext) begin
            ctrl.id_ex_we    = 1'b0;
            ctrl.ex_mem_we   = 1'b0;
            ctrl.front_stall = 1'b1;
          end else if (bus.flush_req) begin
            ctrl.id_ex_clr   = 1'b1;
          end else if (bus.ex_dist_op) begin
            ctrl.dalu_start  = 1'b1;
            ctrl.id_ex_we    = 1'b0;
            ctrl.ex_mem_clr  = 1'b1;
            ctrl.front_stall = 1'b1;
            state_d          = BUSY;
            cnt_d            = CNT_LOAD;
          end else if (hazard) begin
            ctrl.id_ex_clr   = 1'b1;
            ctrl.front_stall = 1'b1;
          end
        end
        BUSY: begin
          ctrl.busy = 1'b1;
          if (cnt_q != '0) begin
            ctrl.id_ex_we    = 1'b0;
            ctrl.ex_mem_clr  = 1'b1;
            ctrl.front_stall = 1'b1;
            ctrl.ex_mem_we   = ~bus.stall_ext;
            cnt_d            = cnt_q - CNT_ONE;
          end else if (bus.stall_ext) begin
            ctrl.id_ex_we    = 1'b0;
            ctrl.ex_mem_we   = 1'b0;
            ctrl.front_stall = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
        default: begin
          state_d = RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State and latency counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.id_ex_we    = ctrl.id_ex_we;
  assign bus.id_ex_clr   = ctrl.id_ex_clr;
  assign bus.ex_mem_we   = ctrl.ex_mem_we;
  assign bus.ex_mem_clr  = ctrl.ex_mem_clr;
  assign bus.front_stall = ctrl.front_stall;
  assign bus.dalu_start  = ctrl.dalu_start;
  assign bus.busy        = ctrl.busy;

endmodule

// File: tb/tb_dist_pipe_ctrl.sv
// Directed bench for dist_pipe_ctrl.
// Vector table for RUN-state decode plus DALU/stall/reset sequences.
module tb_dist_pipe_ctrl;
  import dist_pipe_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  dist_pipe_ctrl_if bus ();

  dist_pipe_ctrl #(.DALU_LAT(4), .CNT_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Field order: id_ex_we id_ex_clr ex_mem_we ex_mem_clr
  //              front_stall dalu_start busy
  localparam logic [6:0] E_IDLE = 7'b1010000;
  localparam logic [6:0] E_RST  = 7'b1111100;
  localparam logic [6:0] E_LU   = 7'b1110100;
  localparam logic [6:0] E_FL   = 7'b1110000;
  localparam logic [6:0] E_STL  = 7'b0000100;
  localparam logic [6:0] E_DS   = 7'b0011110;
  localparam logic [6:0] E_BZ   = 7'b0011101;
  localparam logic [6:0] E_BZS  = 7'b0001101;
  localparam logic [6:0] E_HOLD = 7'b0000101;
  localparam logic [6:0] E_DONE = 7'b1010001;

  typedef struct {
    logic       vld;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       ld;
    logic [4:0] rd;
    logic       fl;
    logic       st;
    logic [6:0] exp;
  } vec_t;

  vec_t vt[13];

  // The source must never flush or load behind a running DALU op.
  always @(posedge clk) begin
    if (rst_n && bus.busy)
      assert (!(bus.flush_req || bus.ex_dist_load))
        else $error("flush/load asserted while busy");
  end

  function automatic logic [6:0] act();
    return {bus.id_ex_we, bus.id_ex_clr, bus.ex_mem_we,
            bus.ex_mem_clr, bus.front_stall, bus.dalu_start,
            bus.busy};
  endfunction

  task automatic check(input string nm, input logic [6:0] exp);
    logic [6:0] a;
    a = act();
    n_chk++;
    if (a !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, a, exp);
    end
  endtask

  task automatic idle_in();
    bus.id_valid     = 1'b0;
    bus.id_rs1       = '0;
    bus.id_rs2       = '0;
    bus.ex_dist_op   = 1'b0;
    bus.ex_dist_load = 1'b0;
    bus.ex_rd        = '0;
    bus.flush_req    = 1'b0;
    bus.stall_ext    = 1'b0;
  endtask

  // Advance to the next cycle: inputs change just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid(input string nm, input logic [6:0] exp);
    @(negedge clk);
    check(nm, exp);
  endtask

  initial begin
    vt[0]  = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE};
    vt[1]  = '{1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE};
    vt[2]  = '{1'b1, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, E_LU};
    vt[3]  = '{1'b1, 5'd7, 5'd2, 1'b1, 5'd7, 1'b0, 1'b0, E_LU};
    vt[4]  = '{1'b1, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0, E_IDLE};
    vt[5]  = '{1'b0, 5'd7, 5'd7, 1'b1, 5'd7, 1'b0, 1'b0, E_IDLE};
    vt[6]  = '{1'b1, 5'd6, 5'd8, 1'b1, 5'd7, 1'b0, 1'b0, E_IDLE};
    vt[7]  = '{1'b1, 5'd7, 5'd7, 1'b0, 5'd7, 1'b0, 1'b0, E_IDLE};
    vt[8]  = '{1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 1'b1, 1'b0, E_FL};
    vt[9]  = '{1'b1, 5'd1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b0, E_FL};
    vt[10] = '{1'b1, 5'd3, 5'd4, 1'b0, 5'd0, 1'b1, 1'b1, E_STL};
    vt[11] = '{1'b1, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, 1'b1, E_STL};
    vt[12] = '{1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, E_IDLE};

    idle_in();
    rst_n = 1'b0;
    #1;

    // Reset held three cycles.
    for (int i = 0; i < 3; i++) begin
      mid($sformatf("reset_%0d", i), E_RST);
      step();
    end
    rst_n = 1'b1;
    mid("post_reset", E_IDLE);

    // RUN-state decode table.
    for (int i = 0; i < 13; i++) begin
      step();
      bus.id_valid     = vt[i].vld;
      bus.id_rs1       = vt[i].rs1;
      bus.id_rs2       = vt[i].rs2;
      bus.ex_dist_load = vt[i].ld;
      bus.ex_rd        = vt[i].rd;
      bus.flush_req    = vt[i].fl;
      bus.stall_ext    = vt[i].st;
      mid($sformatf("vec_%0d", i), vt[i].exp);
    end

    // DALU op, no external stall.
    step();
    idle_in();
    bus.ex_dist_op = 1'b1;
    mid("dalu_t0", E_DS);
    for (int k = 1; k <= 3; k++) begin
      step();
      mid($sformatf("dalu_t%0d", k), E_BZ);
    end
    step();
    mid("dalu_done", E_DONE);
    step();
    bus.ex_dist_op = 1'b0;
    mid("dalu_after", E_IDLE);

    // DALU op with stall_ext over t+2..t+6.
    step();
    bus.ex_dist_op = 1'b1;
    mid("stl_t0", E_DS);
    step();
    mid("stl_t1", E_BZ);
    for (int k = 2; k <= 6; k++) begin
      step();
      bus.stall_ext = 1'b1;
      mid($sformatf("stl_t%0d", k), (k < 4) ? E_BZS : E_HOLD);
    end
    step();
    bus.stall_ext = 1'b0;
    mid("stl_done", E_DONE);
    step();
    bus.ex_dist_op = 1'b0;
    mid("stl_after", E_IDLE);

    // Reset two cycles into BUSY abandons the op.
    step();
    bus.ex_dist_op = 1'b1;
    mid("rb_t0", E_DS);
    step();
    mid("rb_t1", E_BZ);
    step();
    rst_n = 1'b0;
    mid("rb_reset", E_RST);
    step();
    rst_n = 1'b1;
    bus.ex_dist_op = 1'b0;
    mid("rb_run", E_IDLE);
    for (int k = 0; k < 4; k++) begin
      step();
      mid($sformatf("rb_idle_%0d", k), E_IDLE);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
